// File: rtl/unidad_busqueda_pkg.sv
// Shared definitions for the accumulator CPU fetch path: state encoding,
// branch-class opcode, condition codes and default widths.
package paquete_cpu;

   localparam int ANCHO_PC_DEF    = 10;
   localparam int ANCHO_INSTR_DEF = 16;
   localparam int ANCHO_OP        = 6;

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      EXEC  = 2'b01,
      HALT  = 2'b10
   } estado_t;

   // opcode[5:2] value shared by every branch instruction
   localparam logic [3:0] OP_SALTO = 4'b1111;

   localparam logic [1:0] CC_INCOND = 2'b00;
   localparam logic [1:0] CC_JZ     = 2'b01;
   localparam logic [1:0] CC_JNZ    = 2'b10;
   localparam logic [1:0] CC_HALT   = 2'b11;

endpackage

// File: rtl/unidad_busqueda_contador_programa.sv
// Program counter register with its next-value mux: load a jump target,
// step by one (wrapping at 2^ANCHO_PC) or hold.
module contador_programa
   import paquete_cpu::*;
#(
   parameter int ANCHO_PC = ANCHO_PC_DEF
) (
   input  logic                reloj,
   input  logic                reset,
   input  logic                carga,
   input  logic                incrementa,
   input  logic [ANCHO_PC-1:0] destino,
   output logic [ANCHO_PC-1:0] pc
);

   localparam logic [ANCHO_PC-1:0] UNO = 1;

   logic [ANCHO_PC-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (carga)
         pc_d = destino;
      else if (incrementa)
         pc_d = pc_q + UNO;
   end

   always_ff @(posedge reloj or negedge reset) begin
      if (!reset)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch/sequencer: fetches words over req/ack, holds them in IR,
// presents the opcode for one EXEC cycle and picks the next PC from s_inc/z.
module unidad_busqueda
   import paquete_cpu::*;
#(
   parameter int ANCHO_PC    = ANCHO_PC_DEF,
   parameter int ANCHO_INSTR = ANCHO_INSTR_DEF
) (
   input  logic                   reloj,
   input  logic                   reset,
   input  logic                   marcha,
   output logic                   mem_req,
   output logic [ANCHO_PC-1:0]    mem_addr,
   input  logic                   mem_ack,
   input  logic [ANCHO_INSTR-1:0] mem_dato,
   output logic [ANCHO_OP-1:0]    opcode,
   output logic                   instr_valida,
   input  logic                   s_inc,
   input  logic                   z,
   output logic [ANCHO_PC-1:0]    pc,
   output logic                   parado
);

   estado_t                estado_q, estado_d;
   logic [ANCHO_INSTR-1:0] ir_q, ir_d;
   logic                   carga, incrementa;
   logic [1:0]             cc;

   assign opcode = ir_q[ANCHO_INSTR-1 -: ANCHO_OP];
   assign cc     = opcode[1:0];

   // The request is gated by reset so it drops the instant reset asserts,
   // not at the next clock edge.
   assign mem_req      = (estado_q == FETCH) && marcha && reset;
   assign mem_addr     = pc;
   assign instr_valida = (estado_q == EXEC);
   assign parado       = (estado_q == HALT);

   always_comb begin
      estado_d   = estado_q;
      ir_d       = ir_q;
      carga      = 1'b0;
      incrementa = 1'b0;
      case (estado_q)
         FETCH: begin
            if (mem_req && mem_ack) begin
               ir_d     = mem_dato;
               estado_d = EXEC;
            end
         end
         EXEC: begin
            estado_d = FETCH;
            if (s_inc) begin
               incrementa = 1'b1;
            end else begin
               case (cc)
                  CC_INCOND: carga = 1'b1;
                  CC_JZ: begin
                     carga      = z;
                     incrementa = !z;
                  end
                  CC_JNZ: begin
                     carga      = !z;
                     incrementa = z;
                  end
                  default: estado_d = HALT;
               endcase
            end
         end
         HALT:    estado_d = HALT;
         default: estado_d = FETCH;
      endcase
   end

   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         estado_q <= FETCH;
         ir_q     <= '0;
      end else begin
         estado_q <= estado_d;
         ir_q     <= ir_d;
      end
   end

   contador_programa #(
      .ANCHO_PC (ANCHO_PC)
   ) u_contador (
      .reloj      (reloj),
      .reset      (reset),
      .carga      (carga),
      .incrementa (incrementa),
      .destino    (ir_q[ANCHO_PC-1:0]),
      .pc         (pc)
   );

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
Instruction fetch/sequencer for the small accumulator-style CPU. It owns the program counter and fetches 16-bit instruction words from program memory over a req/ack handshake. It presents the 6-bit opcode to the control unit and consumes the control unit's s_inc to select PC+1 or a jump target, gated by the zero flag. It is the producer of `opcode` and the consumer of `s_inc`, i.e. the other end of the control unit interface.

Parameters:
ANCHO_PC, 10, program counter and jump target width
ANCHO_INSTR, 16, instruction word width; opcode = instr[15:10], target = instr[ANCHO_PC-1:0]

Ports:
reloj  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
marcha  input  1  run enable; when 0 no new fetch is started
mem_req  output  1  program memory read request
mem_addr  output  ANCHO_PC  program memory address (= pc while mem_req=1)
mem_ack  input  1  memory response strobe; mem_dato valid in same cycle
mem_dato  input  ANCHO_INSTR  instruction word
opcode  output  6  to control unit; meaningful only while instr_valida=1
instr_valida  output  1  one-cycle strobe, instruction in execute
s_inc  input  1  from control unit: 1 = sequential, 0 = branch instruction
z  input  1  zero flag from datapath, sampled in EXEC
pc  output  ANCHO_PC  current program counter (debug/observe)
parado  output  1  sticky halt indicator

Behaviour:
- Reset (reset=0, asynchronous) sets state=FETCH, pc=0, IR=0, and parado=0. It also forces mem_req=0, instr_valida=0, and opcode=0. Reset applied mid-fetch drops mem_req immediately; a late mem_ack after reset is ignored.
- States: FETCH, EXEC, HALT. Encoding is 2-bit, defined in the package.
- FETCH:
  - mem_req = marcha. mem_addr = pc.
  - The request stays asserted and the address stays stable until mem_ack.
  - On mem_ack=1 with mem_req=1, IR <= mem_dato and the next state is EXEC.
  - mem_ack while marcha=0 is ignored. If marcha drops mid-wait, mem_req deasserts and the fetch is re-issued when marcha returns.
- EXEC (exactly one cycle):
  - instr_valida=1, opcode=IR[15:10], and mem_req=0. The control unit decodes combinationally in this cycle.
  - Next PC:
    - s_inc=1: pc+1, modulo 2^ANCHO_PC (max wraps to 0).
    - s_inc=0: branch. Condition cc = IR[11:10].
      - cc=00 unconditional: pc <= target.
      - cc=01 JZ: pc <= target if z=1, else pc+1.
      - cc=10 JNZ: pc <= target if z=0, else pc+1.
      - cc=11 HALT: pc unchanged, next state HALT.
  - Non-halt outcomes return to FETCH.
- HALT: parado=1. No requests are issued and marcha is ignored. The only exit is reset.
- Throughput: minimum 2 cycles/instruction (ack in the first FETCH cycle). Each memory wait cycle adds one cycle.
- mem_ack in EXEC or HALT is ignored. No state or IR change.
- The pc output is registered and updates on the EXEC→FETCH edge. A jump to the current pc (self-loop) is legal.

Decomposition:
- Package paquete_cpu:
  - state encoding (FETCH/EXEC/HALT)
  - OP_SALTO = 4'b1111 (opcode[5:2] branch class)
  - condition codes CC_INCOND/CC_JZ/CC_JNZ/CC_HALT
  - default widths
- Sub-module contador_programa: pc register plus next-PC mux. Inputs: carga, destino, incrementa. It keeps the arithmetic and wrap separate from the FSM.

Test Plan:
- Reset release, marcha=1, memory with 0-cycle ack returning ALU ops at addresses 0..3 → mem_addr 0,1,2,3 on successive FETCH cycles; instr_valida every 2nd cycle; opcode matches word[15:10].
- Memory delays ack 3 cycles → mem_req held high and mem_addr stable for 4 cycles; exactly one instr_valida pulse.
- Word 0xF005 (uncond, target 5) at pc=2 with s_inc=0 → next mem_addr=5. Word JZ to 0x20: with z=0 → pc=3; with z=1 → pc=0x20.
- pc=0x3FF sequential instruction → next mem_addr=0x000.
- Word 0xFC00 (cc=11) → parado=1, mem_req stays 0 for 20 cycles regardless of marcha; reset=0 then 1 → fetch resumes at 0.
- Assert reset=0 asynchronously mid-wait (mem_req=1) → mem_req falls the same instant; a stray mem_ack after release does not load IR.
